// File: rtl/stdcell_exer_pkg.sv
// Shared definitions for the 2-input standard-cell exerciser: register map,
// control/status bit positions, FSM encoding and the Wishbone byte-merge helper.
package stdcell_exer_pkg;

    localparam logic [7:0] ADDR_CTRL      = 8'h00;
    localparam logic [7:0] ADDR_STATUS    = 8'h04;
    localparam logic [7:0] ADDR_ITER      = 8'h08;
    localparam logic [7:0] ADDR_SETTLE    = 8'h0C;
    localparam logic [7:0] ADDR_CHAN_BASE = 8'h40;

    localparam int CTRL_START  = 0;
    localparam int CTRL_CONT   = 1;
    localparam int CTRL_STOP   = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ANY_ERR = 2;
    localparam int STAT_SYNC    = 31;

    // Truth table bit v is the expected Y for vector v = {B, A}; 4'b0001 is NOR2.
    localparam logic [3:0] TT_DEFAULT = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } exer_state_e;

    function automatic logic [31:0] wb_merge(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = sel[i] ? wdat[8*i +: 8] : cur[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/stdcell_exer_chan.sv
// One cell-under-test channel: truth-table register, optional input synchroniser
// (STDCELL_EXER_SYNC_EN), compare against the table and a saturating error counter.
module stdcell_exer_chan
    import stdcell_exer_pkg::*;
#(
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tt_we,
    input  logic [3:0]       tt_wdata,
    input  logic             clr,
    input  logic             sample_en,
    input  logic [1:0]       vec,
    input  logic             y,
    output logic [3:0]       tt,
    output logic [ERR_W-1:0] err_cnt
);

    logic [3:0]       tt_q;
    logic [ERR_W-1:0] err_q;
    logic             y_cmp;
    logic             mismatch;

`ifdef STDCELL_EXER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], y};
        end
    end

    assign y_cmp = sync_q[1];
`else
    assign y_cmp = y;
`endif

    // The table is read only in SAMPLE, so a rewrite mid-run lands at the next sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_q <= TT_DEFAULT;
        end else if (tt_we) begin
            tt_q <= tt_wdata;
        end
    end

    assign mismatch = (y_cmp != tt_q[vec]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (clr) begin
            err_q <= '0;
        end else if (sample_en && mismatch && (err_q != {ERR_W{1'b1}})) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign tt      = tt_q;
    assign err_cnt = err_q;

endmodule

// File: rtl/stdcell_exerciser.sv
// Wishbone-controlled exhaustive tester for NUM_CH 2-input cells. Define
// STDCELL_EXER_SYNC_EN to synchronise dut_y_i (adds two settle cycles per vector).
module stdcell_exerciser
    import stdcell_exer_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int ERR_W    = 16,
    parameter int SETTLE_W = 8,
    parameter int ITER_W   = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic [NUM_CH-1:0] dut_a_o,
    output logic [NUM_CH-1:0] dut_b_o,
    input  logic [NUM_CH-1:0] dut_y_i,
    output logic              busy_o,
    output logic              irq_o
);

`ifdef STDCELL_EXER_SYNC_EN
    localparam logic SYNC_EN = 1'b1;
`else
    localparam logic SYNC_EN = 1'b0;
`endif

    exer_state_e state_q, state_d;

    logic                ack_q;
    logic [31:0]         rdata_q, rdata_c;
    logic                cont_q, irq_en_q, done_q, done_d, irq_q;
    logic [ITER_W-1:0]   iter_q, iter_eff, pass_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [SETTLE_W:0]   settle_eff, settle_cnt_q;
    logic [1:0]          vec_q;
    logic [31:0]         iter_ext, settle_ext;

    logic       wb_req, wb_wr;
    logic [7:0] wb_addr;
    logic       chan_hit;
    logic [3:0] chan_idx;
    logic       start_pulse, stop_pulse, start_go, w1c_done;
    logic       ctrl_wr, tt_wr;
    logic       last_pass, any_err;
    logic       busy_c, drive_en, sample_en, run_clr, done_set;

    logic [3:0]       tt_arr  [16];
    logic [ERR_W-1:0] err_arr [16];

    logic unused_adr;
    assign unused_adr = ^{wbs_adr_i[31:8]};

    // Handshake: a request is seen while ack is low; ack and read data follow
    // one cycle later for exactly one cycle, so back-to-back acks cannot occur.
    assign wb_req   = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign wb_wr    = wb_req & wbs_we_i;
    assign wb_addr  = wbs_adr_i[7:0];
    assign chan_idx = wb_addr[5:2];
    assign chan_hit = (wb_addr[7:6] == ADDR_CHAN_BASE[7:6]) && (wb_addr[1:0] == 2'b00)
                      && ({1'b0, chan_idx} < 5'(NUM_CH));

    assign ctrl_wr     = wb_wr && (wb_addr == ADDR_CTRL) && wbs_sel_i[0];
    assign start_pulse = ctrl_wr && wbs_dat_i[CTRL_START];
    assign stop_pulse  = ctrl_wr && wbs_dat_i[CTRL_STOP];
    assign start_go    = start_pulse && !stop_pulse;
    assign w1c_done    = wb_wr && (wb_addr == ADDR_STATUS) && wbs_sel_i[0] && wbs_dat_i[STAT_DONE];
    assign tt_wr       = wb_wr && chan_hit && wbs_sel_i[0];

    always_comb begin
        iter_ext   = '0;
        settle_ext = '0;
        iter_ext[ITER_W-1:0]     = iter_q;
        settle_ext[SETTLE_W-1:0] = settle_q;
    end

    // Zero-valued SETTLE/ITER are treated as 1.
    assign iter_eff = (iter_q == '0) ? ITER_W'(1) : iter_q;
`ifdef STDCELL_EXER_SYNC_EN
    assign settle_eff = ((settle_q == '0) ? (SETTLE_W+1)'(1) : {1'b0, settle_q})
                        + (SETTLE_W+1)'(2);
`else
    assign settle_eff = (settle_q == '0) ? (SETTLE_W+1)'(1) : {1'b0, settle_q};
`endif

    assign last_pass = ({1'b0, pass_q} + (ITER_W+1)'(1)) >= {1'b0, iter_eff};

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start_go) state_d = ST_APPLY;
            ST_APPLY:  state_d = stop_pulse ? ST_DONE : ST_SETTLE;
            ST_SETTLE: begin
                if (stop_pulse)                      state_d = ST_DONE;
                else if (settle_cnt_q >= settle_eff) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (stop_pulse)                                   state_d = ST_DONE;
                else if ((vec_q == 2'd3) && last_pass && !cont_q) state_d = ST_DONE;
                else                                              state_d = ST_APPLY;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_c    = (state_q != ST_IDLE);
        drive_en  = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
        sample_en = (state_q == ST_SAMPLE);
        run_clr   = (state_q == ST_IDLE) && start_go;
        done_set  = (state_q == ST_DONE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            vec_q        <= '0;
            pass_q       <= '0;
            settle_cnt_q <= '0;
        end else if (run_clr) begin
            vec_q        <= '0;
            pass_q       <= '0;
            settle_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_APPLY:  settle_cnt_q <= (SETTLE_W+1)'(1);
                ST_SETTLE: settle_cnt_q <= settle_cnt_q + 1'b1;
                ST_SAMPLE: begin
                    vec_q <= vec_q + 1'b1;
                    if (vec_q == 2'd3) pass_q <= pass_q + 1'b1;
                end
                ST_DONE:   vec_q <= '0;
                default:   ;
            endcase
        end
    end

    always_comb begin
        done_d = done_q;
        if (w1c_done || run_clr) done_d = 1'b0;
        if (done_set)            done_d = 1'b1;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cont_q   <= 1'b0;
            irq_en_q <= 1'b0;
            iter_q   <= ITER_W'(1);
            settle_q <= SETTLE_W'(1);
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                cont_q   <= wbs_dat_i[CTRL_CONT];
                irq_en_q <= wbs_dat_i[CTRL_IRQ_EN];
            end
            if (wb_wr && (wb_addr == ADDR_ITER)) begin
                iter_q <= ITER_W'(wb_merge(iter_ext, wbs_dat_i, wbs_sel_i));
            end
            if (wb_wr && (wb_addr == ADDR_SETTLE)) begin
                settle_q <= SETTLE_W'(wb_merge(settle_ext, wbs_dat_i, wbs_sel_i));
            end
            done_q <= done_d;
            irq_q  <= done_d & irq_en_q;
        end
    end

    for (genvar ch = 0; ch < 16; ch++) begin : g_chan
        if (ch < NUM_CH) begin : g_on
            stdcell_exer_chan #(.ERR_W(ERR_W)) u_chan (
                .clk       (wb_clk_i),
                .rst_n     (wb_rst_ni),
                .tt_we     (tt_wr && (chan_idx == 4'(ch))),
                .tt_wdata  (wbs_dat_i[3:0]),
                .clr       (run_clr),
                .sample_en (sample_en),
                .vec       (vec_q),
                .y         (dut_y_i[ch]),
                .tt        (tt_arr[ch]),
                .err_cnt   (err_arr[ch])
            );
        end else begin : g_off
            assign tt_arr[ch]  = '0;
            assign err_arr[ch] = '0;
        end
    end

    always_comb begin
        any_err = 1'b0;
        for (int i = 0; i < 16; i++) begin
            any_err = any_err | (|err_arr[i]);
        end
    end

    always_comb begin
        rdata_c = '0;
        case (wb_addr)
            ADDR_CTRL: begin
                rdata_c[CTRL_CONT]   = cont_q;
                rdata_c[CTRL_IRQ_EN] = irq_en_q;
            end
            ADDR_STATUS: begin
                rdata_c[STAT_BUSY]    = busy_c;
                rdata_c[STAT_DONE]    = done_q;
                rdata_c[STAT_ANY_ERR] = any_err;
                rdata_c[STAT_SYNC]    = SYNC_EN;
            end
            ADDR_ITER:   rdata_c = iter_ext;
            ADDR_SETTLE: rdata_c = settle_ext;
            default: begin
                if (chan_hit) begin
                    rdata_c[3:0]        = tt_arr[chan_idx];
                    rdata_c[16 +: ERR_W] = err_arr[chan_idx];
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= wb_req;
            if (wb_req) rdata_q <= rdata_c;
        end
    end

    // Vectors derive from reset-cleared state, so they drop to 0 with the async reset.
    assign dut_a_o   = drive_en ? {NUM_CH{vec_q[0]}} : '0;
    assign dut_b_o   = drive_en ? {NUM_CH{vec_q[1]}} : '0;
    assign busy_o    = busy_c;
    assign irq_o     = irq_q;
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdata_q;

endmodule
